seq_arith_4x1b_serializer: RTL and testbench

Upstream feeder for the bit-serial 4-bit adder. It accepts 4-bit operand pairs over a valid/ready handshake. It emits them LSB-first as two aligned serial streams whose 4-cycle frames line up exactly with the adder's internal frame counter. A one-entry pending buffer lets operand pairs stream back-to-back with no idle frames, and cycles with no data are filled with zero bits, marked invalid.

---
 rtl/seq_arith_4x1b_serializer.sv | 99 +++++++++
 tb/tb_seq_arith_4x1b_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_4x1b_serializer.sv
// Parallel-to-serial feeder for the bit-serial adder: takes operand pairs over valid/ready
// and emits them LSB-first in NBITS-cycle frames aligned to a free-running phase counter.
module seq_arith_4x1b_serializer #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  output logic             out0,
  output logic             out1,
  output logic             out_val,
  output logic             out_first
);

  localparam int PW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(NBITS - 1);

  logic [PW-1:0]    phase_q, phase_d;
  logic [NBITS-1:0] act_a_q, act_a_d;
  logic [NBITS-1:0] act_b_q, act_b_d;
  logic             act_valid_q, act_valid_d;
  logic [NBITS-1:0] pend_a_q, pend_a_d;
  logic [NBITS-1:0] pend_b_q, pend_b_d;
  logic             pend_full_q, pend_full_d;

  logic boundary;
  logic xfer;

  assign boundary = (phase_q == LAST_PHASE);
  // At the frame boundary the pending slot drains into the active frame, so a new pair always fits.
  assign in_rdy   = !pend_full_q || boundary;
  assign xfer     = in_val && in_rdy;

  always_comb begin
    phase_d     = boundary ? '0 : phase_q + 1'b1;
    act_a_d     = act_a_q;
    act_b_d     = act_b_q;
    act_valid_d = act_valid_q;
    pend_a_d    = pend_a_q;
    pend_b_d    = pend_b_q;
    pend_full_d = pend_full_q;

    if (boundary) begin
      if (pend_full_q) begin
        act_a_d     = pend_a_q;
        act_b_d     = pend_b_q;
        act_valid_d = 1'b1;
        if (xfer) begin
          pend_a_d = in_a;
          pend_b_d = in_b;
        end else begin
          pend_full_d = 1'b0;
        end
      end else if (xfer) begin
        act_a_d     = in_a;
        act_b_d     = in_b;
        act_valid_d = 1'b1;
      end else begin
        // Idle frame: zero bits keep the downstream adder computing 0+0 with carry cleared.
        act_a_d     = '0;
        act_b_d     = '0;
        act_valid_d = 1'b0;
      end
    end else if (xfer) begin
      pend_a_d    = in_a;
      pend_b_d    = in_b;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      act_a_q     <= '0;
      act_b_q     <= '0;
      act_valid_q <= 1'b0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      pend_full_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      act_a_q     <= act_a_d;
      act_b_q     <= act_b_d;
      act_valid_q <= act_valid_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign out0      = act_a_q[phase_q];
  assign out1      = act_b_q[phase_q];
  assign out_val   = act_valid_q;
  assign out_first = act_valid_q && (phase_q == '0);

endmodule

// File: tb/tb_seq_arith_4x1b_serializer.sv
// Scoreboard bench for the serializer: accepted pairs are queued and each frame start pops
// the next expected pair; every cycle's serial bits and handshake are compared.
module tb_seq_arith_4x1b_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_val = 1'b0;
  logic [3:0] in_a = 4'h0;
  logic [3:0] in_b = 4'h0;
  logic       in_rdy, out0, out1, out_val, out_first;

  seq_arith_4x1b_serializer #(.NBITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_a     (in_a),
    .in_b     (in_b),
    .out0     (out0),
    .out1     (out1),
    .out_val  (out_val),
    .out_first(out_first)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
  } pair_t;

  pair_t      sb[$];
  int         cyc;
  logic       cur_v;
  logic [3:0] cur_a, cur_b;
  logic [3:0] sum_reg;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // Entered at a falling edge; leaves at the falling edge that starts cycle 0.
  task automatic do_reset();
    reset  = 1'b1;
    in_val = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_out0", {31'd0, out0}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    sb.delete();
    cur_v = 1'b0;
    cur_a = 4'h0;
    cur_b = 4'h0;
  endtask

  // One cycle: drive inputs, check outputs against the expected frame, record a transfer.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, output logic took);
    int   ph;
    logic exp_rdy;
    pair_t p;
    in_val = v;
    in_a   = a;
    in_b   = b;
    #1;
    ph = cyc % 4;
    if (ph == 0) begin
      if (sb.size() > 0) begin
        p     = sb.pop_front();
        cur_v = 1'b1;
        cur_a = p.a;
        cur_b = p.b;
      end else begin
        cur_v = 1'b0;
        cur_a = 4'h0;
        cur_b = 4'h0;
      end
      sum_reg = cur_a + cur_b;
    end
    exp_rdy = (sb.size() == 0) || (ph == 3);
    chk("out0", {31'd0, out0}, {31'd0, cur_a[ph]});
    chk("out1", {31'd0, out1}, {31'd0, cur_b[ph]});
    chk("out_val", {31'd0, out_val}, {31'd0, cur_v});
    chk("out_first", {31'd0, out_first}, {31'd0, cur_v && (ph == 0)});
    chk("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
    took = v && exp_rdy;
    if (took) begin
      p.a = a;
      p.b = b;
      sb.push_back(p);
      $display("accept cyc=%0d a=%h b=%h", cyc, a, b);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    logic t;
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, t);
  endtask

  // Offer a pair until accepted, within a cycle budget; reports the acceptance cycle.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input int budget, output int acc_cyc);
    logic t;
    t = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < budget && !t; i++) begin
      acc_cyc = cyc;
      step(1'b1, a, b, t);
    end
    if (!t) begin
      acc_cyc = -1;
      chk("send_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    int   acc;
    logic t;
    @(negedge clk);

    // Idle after reset
    do_reset();
    idle(12);

    // Bypass: pair offered only at the frame boundary
    do_reset();
    idle(3);
    step(1'b1, 4'b1011, 4'b0110, t);
    chk("bypass_took", {31'd0, t}, 32'd1);
    step(1'b0, 4'h0, 4'h0, t);
    chk("bypass_sum", {28'd0, sum_reg}, 32'h1);
    idle(7);

    // Pending path: accepted at phase 0, held for the next frame
    do_reset();
    send(4'h5, 4'h3, 4, acc);
    chk("pend_acc", acc, 32'd0);
    idle(11);

    // Back-to-back stream with in_val held high
    do_reset();
    send(4'h1, 4'h0, 10, acc);
    chk("b2b_acc0", acc, 32'd0);
    send(4'h2, 4'h0, 10, acc);
    chk("b2b_acc1", acc, 32'd3);
    send(4'h3, 4'h0, 10, acc);
    chk("b2b_acc2", acc, 32'd7);
    idle(12);
    chk("b2b_drain", sb.size(), 32'd0);

    // Reset mid-frame discards the active pair
    do_reset();
    idle(3);
    step(1'b1, 4'hF, 4'h0, t);
    idle(1);
    do_reset();
    idle(12);

    // Pending full plus a new pair at the boundary
    do_reset();
    send(4'h9, 4'h6, 4, acc);
    idle(2);
    step(1'b1, 4'hC, 4'h5, t);
    chk("bound_took", {31'd0, t}, 32'd1);
    idle(12);
    chk("bound_drain", sb.size(), 32'd0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 160; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), t);
    idle(12);
    chk("rand_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
